// File: rtl/axi_lite_csr_bridge.sv
// AXI4-Lite slave that turns single-beat reads/writes into one-cycle CSR strobes.
// One transaction in flight; reads and writes share the CSR bus under round-robin arbitration.
module axi_lite_csr_bridge #(
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned CSR_WIDTH_AD = 8,
  parameter bit          RD_FIRST     = 1'b1
) (
  input  logic                    reset_n,
  input  logic                    clk,
  input  logic [AXI_WIDTH_AD-1:0] s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_WIDTH_AD-1:0] s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [CSR_WIDTH_AD-1:0] csr_addr,
  output logic                    csr_rden,
  output logic                    csr_wren,
  output logic [31:0]             csr_wdata,
  input  logic [31:0]             csr_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WR_STB,
    WR_RSP,
    RD_STB,
    RD_CAP,
    RD_RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e                  state_q,     state_d;
  logic [CSR_WIDTH_AD-1:0] csr_addr_q,  csr_addr_d;
  logic [31:0]             csr_wdata_q, csr_wdata_d;
  logic                    csr_wren_q,  csr_wren_d;
  logic                    csr_rden_q,  csr_rden_d;
  logic                    bvalid_q,    bvalid_d;
  logic [1:0]              bresp_q,     bresp_d;
  logic                    rvalid_q,    rvalid_d;
  logic [1:0]              rresp_q,     rresp_d;
  logic [31:0]             rdata_q,     rdata_d;
  logic                    err_q,       err_d;
  logic                    last_rd_q,   last_rd_d;

  logic wr_req;
  logic rd_req;
  logic grant_rd;
  logic grant_wr;
  logic in_idle;
  logic wr_err;
  logic rd_err;
  logic unused_addr_bits;

  // Address decode happens upstream; only the low CSR bits matter here.
  assign unused_addr_bits = ^{s_axi_awaddr[AXI_WIDTH_AD-1:CSR_WIDTH_AD],
                              s_axi_araddr[AXI_WIDTH_AD-1:CSR_WIDTH_AD]};

  assign wr_req  = s_axi_awvalid & s_axi_wvalid;
  assign rd_req  = s_axi_arvalid;
  assign in_idle = (state_q == IDLE);
  // last_rd_q set means the read side wins the next contested cycle.
  assign grant_rd = rd_req & (~wr_req | last_rd_q);
  assign grant_wr = wr_req & ~grant_rd;

  assign wr_err = (s_axi_wstrb != 4'hF) | (s_axi_awaddr[1:0] != 2'b00);
  assign rd_err = (s_axi_araddr[1:0] != 2'b00);

  assign s_axi_awready = in_idle & grant_wr;
  assign s_axi_wready  = in_idle & grant_wr;
  assign s_axi_arready = in_idle & grant_rd;

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign csr_addr     = csr_addr_q;
  assign csr_wdata    = csr_wdata_q;
  assign csr_wren     = csr_wren_q;
  assign csr_rden     = csr_rden_q;

  always_comb begin
    state_d     = state_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_wren_d  = 1'b0;
    csr_rden_d  = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    last_rd_d   = last_rd_q;
    unique case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d    = RD_STB;
          csr_addr_d = s_axi_araddr[CSR_WIDTH_AD-1:0];
          csr_rden_d = ~rd_err;
          err_d      = rd_err;
          last_rd_d  = 1'b0;
        end else if (grant_wr) begin
          state_d     = WR_STB;
          csr_addr_d  = s_axi_awaddr[CSR_WIDTH_AD-1:0];
          csr_wdata_d = s_axi_wdata;
          csr_wren_d  = ~wr_err;
          err_d       = wr_err;
          last_rd_d   = 1'b1;
        end
      end
      WR_STB: begin
        state_d  = WR_RSP;
        bvalid_d = 1'b1;
        bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      WR_RSP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_STB: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        // The CSR core presents read data one cycle after the strobe.
        state_d  = RD_RSP;
        rvalid_d = 1'b1;
        rdata_d  = err_q ? '0 : csr_rdata;
        rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      RD_RSP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wren_q  <= 1'b0;
      csr_rden_q  <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      last_rd_q   <= RD_FIRST;
    end else begin
      state_q     <= state_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_wren_q  <= csr_wren_d;
      csr_rden_q  <= csr_rden_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      last_rd_q   <= last_rd_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_csr_bridge.sv
// Directed bench for axi_lite_csr_bridge: strobes, responses, arbitration order,
// back-pressure during a stalled read response, and reset mid-transaction.
`timescale 1ns/1ps
module tb_axi_lite_csr_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  csr_addr;
  logic        csr_rden;
  logic        csr_wren;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;

  int tests = 0;
  int fails = 0;
  int wren_cnt = 0;
  int rden_cnt = 0;
  int gcnt = 0;
  int glog [32];
  logic [31:0] rd_model_val = '0;

  axi_lite_csr_bridge #(
    .AXI_WIDTH_AD(32),
    .CSR_WIDTH_AD(8),
    .RD_FIRST(1'b1)
  ) dut (
    .reset_n      (reset_n),
    .clk          (clk),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .csr_addr     (csr_addr),
    .csr_rden     (csr_rden),
    .csr_wren     (csr_wren),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata)
  );

  always #5 clk = ~clk;

  // CSR core model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (csr_rden) csr_rdata <= rd_model_val;
    if (csr_wren) wren_cnt = wren_cnt + 1;
    if (csr_rden) rden_cnt = rden_cnt + 1;
    if (reset_n && s_axi_arvalid && s_axi_arready) begin
      glog[gcnt % 32] = 1;
      gcnt = gcnt + 1;
    end else if (reset_n && s_axi_awvalid && s_axi_awready) begin
      glog[gcnt % 32] = 0;
      gcnt = gcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic ok);
    int n;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    #1;
    n = 0;
    while (!s_axi_awready && n < 20) begin cyc(); n++; end
    ok = (n < 20);
    cyc();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin cyc(); n++; end
    ok   = ok && s_axi_bvalid;
    resp = s_axi_bresp;
    cyc();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output logic ok);
    int n;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin cyc(); n++; end
    ok = (n < 20);
    cyc();
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin cyc(); n++; end
    ok   = ok && s_axi_rvalid;
    data = s_axi_rdata;
    resp = s_axi_rresp;
    cyc();
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic        ok;
    int          wb, rb, gb, n;
    logic        stall_ok;

    // Reset values
    do_reset();
    chk("rst_bvalid",  s_axi_bvalid,  0);
    chk("rst_rvalid",  s_axi_rvalid,  0);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wren",    csr_wren,      0);
    chk("rst_rden",    csr_rden,      0);
    chk("rst_addr",    csr_addr,      0);
    chk("rst_wdata",   csr_wdata,     0);
    chk("rst_rdata",   s_axi_rdata,   0);

    // Cycle-accurate OKAY write to 0x14
    s_axi_awaddr = 32'h14; s_axi_wdata = 32'h64; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    #1;
    chk("w1_awready", s_axi_awready, 1);
    chk("w1_wready",  s_axi_wready,  1);
    chk("w1_arready", s_axi_arready, 0);
    cyc();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("w1_wren",    csr_wren,     1);
    chk("w1_addr",    csr_addr,     32'h14);
    chk("w1_wdata",   csr_wdata,    32'h64);
    chk("w1_bv_e0",   s_axi_bvalid, 0);
    cyc();
    chk("w1_wren_off", csr_wren,     0);
    chk("w1_bvalid",   s_axi_bvalid, 1);
    chk("w1_bresp",    s_axi_bresp,  2'b00);
    cyc();
    chk("w1_bv_done",  s_axi_bvalid, 0);
    chk("w1_wren_cnt", wren_cnt,     1);

    // Cycle-accurate OKAY read of 0x00
    rd_model_val = 32'h2024_0810;
    s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    #1;
    chk("r1_arready", s_axi_arready, 1);
    cyc();
    s_axi_arvalid = 1'b0;
    chk("r1_rden",  csr_rden, 1);
    chk("r1_addr",  csr_addr, 0);
    cyc();
    chk("r1_rden_off", csr_rden,     0);
    chk("r1_rv_cap",   s_axi_rvalid, 0);
    cyc();
    chk("r1_rvalid", s_axi_rvalid, 1);
    chk("r1_rdata",  s_axi_rdata,  32'h2024_0810);
    chk("r1_rresp",  s_axi_rresp,  2'b00);
    cyc();
    chk("r1_rv_done",  s_axi_rvalid, 0);
    chk("r1_rden_cnt", rden_cnt,     1);

    // Partial-strobe write and misaligned read give SLVERR without strobes
    wb = wren_cnt; rb = rden_cnt;
    do_write(32'h10, 32'hDEAD_BEEF, 4'h3, resp, ok);
    chk("e_w_ok",   ok,             1);
    chk("e_bresp",  resp,           2'b10);
    chk("e_nowren", wren_cnt - wb,  0);
    rd_model_val = 32'h1111_2222;
    do_read(32'h12, data, resp, ok);
    chk("e_r_ok",   ok,             1);
    chk("e_rresp",  resp,           2'b10);
    chk("e_rdata",  data,           0);
    chk("e_norden", rden_cnt - rb,  0);

    // Simultaneous write pair and AR after reset: read, write, read
    do_reset();
    wb = wren_cnt; rb = rden_cnt; gb = gcnt;
    rd_model_val  = 32'h0BAD_CAFE;
    s_axi_awaddr  = 32'h04; s_axi_wdata = 32'hA5; s_axi_wstrb = 4'hF;
    s_axi_araddr  = 32'h08;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready  = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while ((gcnt - gb) < 3 && n < 40) begin cyc(); n++; end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    repeat (8) cyc();
    chk("arb_grants", gcnt - gb,             3);
    chk("arb_g0",     glog[gb % 32],         1);
    chk("arb_g1",     glog[(gb + 1) % 32],   0);
    chk("arb_g2",     glog[(gb + 2) % 32],   1);
    chk("arb_rden",   rden_cnt - rb,         2);
    chk("arb_wren",   wren_cnt - wb,         1);

    // Stalled R response with a write pending behind it
    rd_model_val = 32'hCAFE_F00D;
    s_axi_araddr = 32'h20; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin cyc(); n++; end
    cyc();
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin cyc(); n++; end
    chk("st_rvalid", s_axi_rvalid, 1);
    s_axi_awaddr = 32'h30; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    wb = wren_cnt;
    stall_ok = 1'b1;
    repeat (10) begin
      cyc();
      if (s_axi_rdata !== 32'hCAFE_F00D || s_axi_awready !== 1'b0 ||
          s_axi_rvalid !== 1'b1 || csr_wren !== 1'b0) stall_ok = 1'b0;
    end
    chk("st_hold",   stall_ok,      1);
    chk("st_nowren", wren_cnt - wb, 0);
    s_axi_rready = 1'b1;
    cyc();
    chk("st_rv_done", s_axi_rvalid,  0);
    chk("st_wren_h",  csr_wren,      0);
    chk("st_awready", s_axi_awready, 1);
    cyc();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("st_wren",  csr_wren,  1);
    chk("st_addr",  csr_addr,  32'h30);
    chk("st_wdata", csr_wdata, 32'h1234_5678);
    repeat (3) cyc();
    chk("st_wcnt", wren_cnt - wb, 1);

    // Reset asserted while the write response is pending
    s_axi_awaddr = 32'h40; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    #1;
    n = 0;
    while (!s_axi_awready && n < 20) begin cyc(); n++; end
    cyc();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin cyc(); n++; end
    chk("rs_bvalid_pre", s_axi_bvalid, 1);
    wb = wren_cnt;
    reset_n = 1'b0;
    #1;
    chk("rs_bvalid_async", s_axi_bvalid, 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (2) cyc();
    chk("rs_bvalid", s_axi_bvalid, 0);
    chk("rs_addr",   csr_addr,     0);
    chk("rs_wdata",  csr_wdata,    0);
    chk("rs_rdata",  s_axi_rdata,  0);
    chk("rs_bresp",  s_axi_bresp,  0);
    chk("rs_nowren", wren_cnt - wb, 0);
    do_write(32'h08, 32'h77, 4'hF, resp, ok);
    chk("rs_w_ok",   ok,   1);
    chk("rs_w_resp", resp, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
